rejection_sampler_ctrl: RTL and testbench



---
 rtl/sampler_pkg.sv | 15 +
 rtl/xorshift64_gen.sv | 17 +
 rtl/rejection_sampler_ctrl.sv | 91 +++++++++
 tb/tb_rejection_sampler_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sampler_pkg.sv
// sampler_pkg: shared state encoding and xorshift64 constants for the rejection sampler.
package sampler_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_CHECK, S_HOLD, S_DONE} smp_state_t;
  localparam logic [63:0] XS_DEFAULT_SEED = 64'h9E37_79B9_7F4A_7C15;
  localparam int XS_A = 13;
  localparam int XS_B = 7;
  localparam int XS_C = 17;
  function automatic logic [63:0] xs_next(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << XS_A);
    y = y ^ (y >> XS_B);
    y = y ^ (y << XS_C);
    return y;
  endfunction
endpackage

// File: rtl/xorshift64_gen.sv
// xorshift64_gen: 64-bit xorshift PRNG; rnd_o is the next state, committed when step_i is high.
module xorshift64_gen import sampler_pkg::*; #(
  parameter logic [63:0] SEED = XS_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_i,
  output logic [63:0] rnd_o
);
  // an all-zero state would lock the generator at zero forever
  localparam logic [63:0] INIT = (SEED == 64'd0) ? 64'd1 : SEED;
  logic [63:0] state;
  assign rnd_o = xs_next(state);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else if (step_i) state <= rnd_o;
endmodule

// File: rtl/rejection_sampler_ctrl.sv
// rejection_sampler_ctrl: drives random candidates into an external checker and
// forwards satisfying ones over valid/ready, with a per-sample attempt budget.
module rejection_sampler_ctrl import sampler_pkg::*; #(
  parameter int          VEC_W     = 64,
  parameter int          MAX_TRIES = 1024,
  parameter logic [63:0] SEED      = XS_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [15:0]      num_samples_i,
  output logic [VEC_W-1:0] cand_o,
  input  logic             sat_i,
  output logic [VEC_W-1:0] sample_o,
  output logic             sample_valid_o,
  input  logic             sample_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [31:0]      attempts_o
);
  localparam int NW = (VEC_W + 63) / 64;
  localparam int FW = NW > 1 ? $clog2(NW) : 1;
  localparam int TW = $clog2(MAX_TRIES + 1);
  smp_state_t state, nxt;
  logic [15:0] remaining;
  logic [TW-1:0] tries, tries_inc;
  logic [FW-1:0] fill_cnt;
  logic fill_last, try_last, step;
  logic [63:0] rnd;
  logic [VEC_W-1:0] cand_nxt;
  xorshift64_gen #(.SEED(SEED)) u_gen (.clk(clk), .rst_n(rst_n), .step_i(step), .rnd_o(rnd));
  assign step = state == S_FILL;
  assign tries_inc = tries + TW'(1);
  assign try_last = tries_inc == TW'(MAX_TRIES);
  assign fill_last = fill_cnt == FW'(NW - 1);
  assign busy_o = state inside {S_FILL, S_CHECK, S_HOLD};
  assign done_o = state == S_DONE;
  assign sample_valid_o = state == S_HOLD;
  // new generator words enter at the MSB end, older words slide toward the LSBs
  generate
    if (VEC_W > 64) begin : g_wide
      assign cand_nxt = {rnd, cand_o[VEC_W-1:64]};
    end else begin : g_narrow
      assign cand_nxt = rnd[63 -: VEC_W];
    end
  endgenerate
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_i) nxt = num_samples_i == 16'd0 ? S_DONE : S_FILL;
      S_FILL:         if (fill_last) nxt = S_CHECK;
      S_CHECK:        nxt = sat_i ? S_HOLD : (try_last ? S_DONE : S_FILL);
      S_HOLD:         if (sample_ready_i) nxt = remaining == 16'd1 ? S_DONE : S_FILL;
      default:        nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      cand_o     <= '0;
      sample_o   <= '0;
      remaining  <= '0;
      tries      <= '0;
      fill_cnt   <= '0;
      timeout_o  <= 1'b0;
      attempts_o <= '0;
    end else begin
      state <= nxt;
      case (state)
        S_IDLE, S_DONE: if (start_i) begin
          remaining  <= num_samples_i;
          attempts_o <= '0;
          timeout_o  <= 1'b0;
          tries      <= '0;
        end
        S_FILL: begin
          cand_o   <= cand_nxt;
          fill_cnt <= fill_last ? '0 : fill_cnt + FW'(1);
        end
        S_CHECK: begin
          attempts_o <= attempts_o + 32'(~&attempts_o);
          tries      <= sat_i ? '0 : tries_inc;
          if (sat_i) sample_o <= cand_o;
          if (!sat_i && try_last) timeout_o <= 1'b1;
        end
        S_HOLD: if (sample_ready_i) remaining <= remaining - 16'd1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_rejection_sampler_ctrl.sv
// tb_rejection_sampler_ctrl: table-driven, randomized and hand-written checks of the
// rejection sampler against a queue-based behavioural model.
module tb_rejection_sampler_ctrl;
  localparam logic [63:0] SEED_A = 64'h9E37_79B9_7F4A_7C15;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start_a = 1'b0, start_b = 1'b0, ready = 1'b1;
  logic [15:0] num = '0;
  int mode = 1;
  logic [63:0] cand_a, sample_a;
  logic [99:0] cand_b, sample_b;
  logic sat_a, sat_b, valid_a, valid_b, busy_a, busy_b, done_a, done_b, to_a, to_b;
  logic [31:0] att_a, att_b;
  assign sat_a = mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : cand_a[0];
  assign sat_b = cand_b[0];
  rejection_sampler_ctrl #(.VEC_W(64), .MAX_TRIES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .num_samples_i(num), .cand_o(cand_a),
    .sat_i(sat_a), .sample_o(sample_a), .sample_valid_o(valid_a), .sample_ready_i(ready),
    .busy_o(busy_a), .done_o(done_a), .timeout_o(to_a), .attempts_o(att_a));
  rejection_sampler_ctrl #(.VEC_W(100), .MAX_TRIES(1024), .SEED(64'd0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .num_samples_i(num), .cand_o(cand_b),
    .sat_i(sat_b), .sample_o(sample_b), .sample_valid_o(valid_b), .sample_ready_i(ready),
    .busy_o(busy_b), .done_o(done_b), .timeout_o(to_b), .attempts_o(att_b));
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    return y ^ (y << 17);
  endfunction
  logic [63:0] gen_m [2];
  logic [127:0] exp_q [$];
  logic [127:0] got [$];
  logic [127:0] first_q [$];
  int exp_att, exp_k;
  bit exp_to;
  logic [31:0] fin_att;
  logic fin_to;
  // candidates are generator words packed newest-at-top; a sample needs a
  // satisfying candidate within the budget, otherwise the run times out
  task automatic model_run(input int sel, input int n);
    int w, nw, maxt, tries;
    logic [127:0] c;
    bit found, ok;
    w = sel ? 100 : 64; nw = sel ? 2 : 1; maxt = sel ? 1024 : 4;
    exp_q.delete(); exp_att = 0; exp_to = 0; exp_k = 0;
    for (int s = 0; s < n && !exp_to; s++) begin
      tries = 0; found = 0;
      while (!found && !exp_to) begin
        c = '0;
        for (int i = 0; i < nw; i++) begin
          gen_m[sel] = xs(gen_m[sel]);
          c = {gen_m[sel], c[127:64]};
        end
        c = c >> (128 - w);
        exp_att++;
        ok = sel ? c[0] : (mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : c[0]);
        if (ok) begin
          exp_q.push_back(c); found = 1;
          if (s == 0) exp_k = exp_att;
        end else begin
          tries++;
          if (tries == maxt) exp_to = 1;
        end
      end
    end
  endtask
  task automatic run(input int sel, input int n, input int stall);
    int cyc, first_valid, done_cyc, nw;
    int vcyc [$];
    bit pv, pr, busy_seen, v, d, bz;
    logic [127:0] s, ps;
    logic [31:0] a, patt;
    nw = sel ? 2 : 1;
    model_run(sel, n);
    @(negedge clk); num = 16'(n); ready = 1'b1;
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk); start_a = 1'b0; start_b = 1'b0;
    cyc = 1; first_valid = 0; done_cyc = 0; pv = 0; pr = 1; ps = '0; patt = '0; busy_seen = 0;
    got.delete(); vcyc.delete();
    while (cyc < 4000) begin
      v = sel ? valid_b : valid_a; d = sel ? done_b : done_a; bz = sel ? busy_b : busy_a;
      s = sel ? 128'(sample_b) : 128'(sample_a); a = sel ? att_b : att_a;
      if (pv && !pr) begin
        chk("stall_valid", 128'(v), 128'(1));
        chk("stall_sample", s, ps);
        chk("stall_attempts", 128'(a), 128'(patt));
      end
      if (v) vcyc.push_back(cyc);
      if (v && first_valid == 0) first_valid = cyc;
      if (bz) busy_seen = 1;
      if (d) begin done_cyc = cyc; break; end
      ready = $urandom_range(99) >= stall;
      if (v && ready) got.push_back(s);
      pv = v; pr = ready; ps = s; patt = a;
      @(negedge clk); cyc++;
    end
    ready = 1'b1;
    fin_att = sel ? att_b : att_a; fin_to = sel ? to_b : to_a;
    chk("done_reached", 128'(done_cyc != 0), 128'(1));
    chk("attempts", 128'(fin_att), 128'(exp_att));
    chk("timeout", 128'(fin_to), 128'(exp_to));
    chk("sample_count", 128'(got.size()), 128'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk("sample_value", got[i], exp_q[i]);
      if (sel != 0) chk("sample_bit0", 128'(got[i][0]), 128'(1));
    end
    if (exp_q.size() > 0) chk("first_latency", 128'(first_valid), 128'(1 + exp_k * (nw + 1)));
    if (exp_q.size() == 0) chk("valid_never", 128'(first_valid), 128'(0));
    if (n == 0) chk("busy_never", 128'(busy_seen), 128'(0));
    if (stall == 0) begin
      chk("done_cycle", 128'(done_cyc), 128'(1 + exp_att * (nw + 1) + exp_q.size()));
      if (mode == 1 && sel == 0)
        for (int i = 1; i < vcyc.size(); i++) chk("spacing", 128'(vcyc[i] - vcyc[i-1]), 128'(nw + 2));
    end
  endtask
  typedef struct {int num; int md; int stall; int att; int to; int ns;} vec_t;
  vec_t tbl [5];
  initial begin
    tbl[0] = '{3, 1, 0, 3, 0, 3};
    tbl[1] = '{2, 0, 0, 4, 1, 0};
    tbl[2] = '{0, 1, 0, 0, 0, 0};
    tbl[3] = '{1, 1, 0, 1, 0, 1};
    tbl[4] = '{2, 1, 50, 2, 0, 2};
    gen_m[0] = SEED_A; gen_m[1] = 64'd1;
    repeat (3) @(negedge clk);
    chk("rst_cand", 128'(cand_a), 128'(0));
    chk("rst_sample", 128'(sample_a), 128'(0));
    chk("rst_flags", 128'({valid_a, busy_a, done_a, to_a}), 128'(0));
    chk("rst_attempts", 128'(att_a), 128'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].md;
      run(0, tbl[i].num, tbl[i].stall);
      chk("tbl_attempts", 128'(fin_att), 128'(tbl[i].att));
      chk("tbl_timeout", 128'(fin_to), 128'(tbl[i].to));
      chk("tbl_count", 128'(got.size()), 128'(tbl[i].ns));
      chk("tbl_done", 128'(done_a), 128'(1));
      if (i == 0) first_q = got;
    end
    mode = 2;
    for (int i = 0; i < 6; i++) run(0, $urandom_range(1, 5), $urandom_range(0, 60));
    mode = 1;
    model_run(0, 2);
    @(negedge clk); num = 16'd2; ready = 1'b0; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int k = 0; k < 20 && !valid_a; k++) @(negedge clk);
    chk("bp_valid_seen", 128'(valid_a), 128'(1));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", 128'(valid_a), 128'(1));
      chk("bp_sample", 128'(sample_a), exp_q[0]);
      chk("bp_attempts", 128'(att_a), 128'(1));
    end
    ready = 1'b1;
    @(negedge clk);
    chk("bp_to_fill", 128'({valid_a, busy_a, done_a}), 128'(3'b010));
    for (int k = 0; k < 20 && !done_a; k++) @(negedge clk);
    chk("bp_done", 128'(done_a), 128'(1));
    chk("bp_attempts_end", 128'(att_a), 128'(2));
    chk("bp_sample2", 128'(sample_a), exp_q[1]);
    @(negedge clk); num = 16'd3; ready = 1'b0; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int k = 0; k < 20 && !valid_a; k++) @(negedge clk);
    chk("rst_pre_hold", 128'(valid_a), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cand", 128'(cand_a), 128'(0));
    chk("arst_sample", 128'(sample_a), 128'(0));
    chk("arst_flags", 128'({valid_a, busy_a, done_a, to_a}), 128'(0));
    chk("arst_attempts", 128'(att_a), 128'(0));
    @(negedge clk); rst_n = 1'b1; ready = 1'b1;
    gen_m[0] = SEED_A; gen_m[1] = 64'd1;
    run(0, 3, 0);
    chk("replay_count", 128'(got.size()), 128'(first_q.size()));
    for (int i = 0; i < got.size() && i < first_q.size(); i++) chk("replay_sample", got[i], first_q[i]);
    run(1, 3, 0);
    run(1, 4, 40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
